// File: rtl/pll_lock_ce_ctrl.sv
// rtl/pll_lock_ce_ctrl.sv - PLL lock qualifier, reset sequencer and phase-aligned clock-enable generator
`timescale 1ns/1ps
module pll_lock_ce_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1,
    parameter int LOCK_SYNC   = 2,
    parameter int LOCK_STABLE = 1024,
    parameter int RST_HOLD    = 16,
    parameter int CNT_W       = 8
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    pll_lock,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    div_load,
    input  logic                    clear_lost,
    output logic                    rst_out,
    output logic                    ready,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    lock_lost,
    output logic [CNT_W-1:0]        lost_cnt
);

    localparam int SEQ_MAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK,
        S_STABLE,
        S_HOLD,
        S_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SEQ_W-1:0]       r_seq_cnt;
    logic [SEQ_W-1:0]       w_seq_next;
    logic [LOCK_SYNC-1:0]   r_sync;
    logic                   w_lock_s;
    logic                   w_loss;
    logic                   w_run_stay;
    logic                   r_rst_out;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic [CNT_W-1:0]       r_lost_cnt;

    assign w_lock_s   = r_sync[LOCK_SYNC-1];
    assign w_loss     = (r_state == S_RUN) && !w_lock_s;
    assign w_run_stay = (r_state == S_RUN) && (w_state_next == S_RUN);

    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;
    assign lost_cnt  = r_lost_cnt;

    // Bring the asynchronous lock indication into the clock domain
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[LOCK_SYNC-2:0], pll_lock};
        end
    end

    // Sequencer next state: qualify lock, hold reset, drop back on any lock loss
    always_comb begin
        w_state_next = r_state;
        w_seq_next   = r_seq_cnt;
        unique case (r_state)
            S_WAIT_LOCK: begin
                w_seq_next = '0;
                if (w_lock_s) begin
                    w_state_next = S_STABLE;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_state_next = S_WAIT_LOCK;
                    w_seq_next   = '0;
                end else if (r_seq_cnt == SEQ_W'(LOCK_STABLE - 1)) begin
                    w_state_next = S_HOLD;
                    w_seq_next   = '0;
                end else begin
                    w_seq_next = r_seq_cnt + SEQ_W'(1);
                end
            end
            S_HOLD: begin
                if (!w_lock_s) begin
                    w_state_next = S_WAIT_LOCK;
                    w_seq_next   = '0;
                end else if (r_seq_cnt == SEQ_W'(RST_HOLD - 1)) begin
                    w_state_next = S_RUN;
                    w_seq_next   = '0;
                end else begin
                    w_seq_next = r_seq_cnt + SEQ_W'(1);
                end
            end
            S_RUN: begin
                w_seq_next = '0;
                if (!w_lock_s) begin
                    w_state_next = S_WAIT_LOCK;
                end
            end
            default: begin
                w_state_next = S_WAIT_LOCK;
                w_seq_next   = '0;
            end
        endcase
    end

    // State register with reset/ready registered alongside the state
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state   <= S_WAIT_LOCK;
            r_seq_cnt <= '0;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_seq_cnt <= w_seq_next;
            r_rst_out <= (w_state_next != S_RUN);
            r_ready   <= (w_state_next == S_RUN);
        end
    end

    // Sticky loss flag and saturating loss counter; a loss beats a clear
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_lock_lost <= 1'b0;
            r_lost_cnt  <= '0;
        end else if (w_loss) begin
            r_lock_lost <= 1'b1;
            if (clear_lost) begin
                r_lost_cnt <= CNT_W'(1);
            end else if (r_lost_cnt != '1) begin
                r_lost_cnt <= r_lost_cnt + CNT_W'(1);
            end
        end else if (clear_lost) begin
            r_lock_lost <= 1'b0;
            r_lost_cnt  <= '0;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] r_shadow;
        logic [DIV_W-1:0] r_active;
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] w_div_eff;
        logic             w_wrap;

        // A new divisor takes effect only at the start of a period (cnt==0)
        assign w_div_eff = (r_cnt == '0) ? r_shadow : r_active;
        assign w_wrap    = (w_div_eff <= DIV_W'(1)) || (r_cnt >= w_div_eff - DIV_W'(1));
        assign ce_out[gi] = (r_state == S_RUN) && (r_cnt == '0);

        // Shadow capture, divisor adoption and the phase counter for this channel
        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_shadow <= DIV_W'(DEFAULT_DIV);
                r_active <= DIV_W'(DEFAULT_DIV);
                r_cnt    <= '0;
            end else begin
                if (div_load) begin
                    r_shadow <= div_cfg[gi*DIV_W +: DIV_W];
                end
                if (r_state != S_RUN) begin
                    r_active <= div_load ? div_cfg[gi*DIV_W +: DIV_W] : r_shadow;
                end else if (r_cnt == '0) begin
                    r_active <= r_shadow;
                end
                if (w_run_stay) begin
                    r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_ce_ctrl.sv
// tb/tb_pll_lock_ce_ctrl.sv - self-checking bench for pll_lock_ce_ctrl
`timescale 1ns/1ps
module tb_pll_lock_ce_ctrl;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 2;
    localparam int REL    = 15;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    pll_lock;
    logic [NUM_CH*DIV_W-1:0] div_cfg;
    logic                    div_load;
    logic                    clear_lost;
    logic                    rst_out;
    logic                    ready;
    logic [NUM_CH-1:0]       ce_out;
    logic                    lock_lost;
    logic [CNT_W-1:0]        lost_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_CH*DIV_W-1:0] div;
        logic [5:0][3:0]         ce;
    } vec_t;

    vec_t vecs [3];

    pll_lock_ce_ctrl #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(1), .LOCK_SYNC(2),
        .LOCK_STABLE(8), .RST_HOLD(4), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk), .reset(reset), .pll_lock(pll_lock), .div_cfg(div_cfg),
        .div_load(div_load), .clear_lost(clear_lost), .rst_out(rst_out),
        .ready(ready), .ce_out(ce_out), .lock_lost(lock_lost), .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        pll_lock   = 1'b0;
        div_load   = 1'b0;
        clear_lost = 1'b0;
        div_cfg    = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (rst_out && n < 40);
        if (rst_out) n = 99;
    endtask

    task automatic wait_loss(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rst_out && n < 6);
        if (!rst_out) n = 99;
    endtask

    task automatic load_div(input logic [NUM_CH*DIV_W-1:0] d);
        div_cfg  = d;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
    endtask

    initial begin
        int n;
        int coinc;
        int dmod [4];
        logic [3:0] exp_ce;
        logic [CNT_W-1:0] exp_lost [4];

        vecs[0].div = {16'd5, 16'd3, 16'd2, 16'd1};
        vecs[0].ce  = {4'b1001, 4'b0011, 4'b0101, 4'b0011, 4'b0001, 4'b1111};
        vecs[1].div = {16'd2, 16'd4, 16'd1, 16'd0};
        vecs[1].ce  = {4'b0011, 4'b1111, 4'b0011, 4'b1011, 4'b0011, 4'b1111};
        vecs[2].div = {16'd7, 16'd7, 16'd7, 16'd7};
        vecs[2].ce  = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
        exp_lost[0] = 2'd1; exp_lost[1] = 2'd2; exp_lost[2] = 2'd3; exp_lost[3] = 2'd3;
        dmod[0] = 1; dmod[1] = 2; dmod[2] = 3; dmod[3] = 5;

        // reset state
        do_reset();
        chk("rst_rst_out", rst_out, 1);
        chk("rst_ready", ready, 0);
        chk("rst_ce", ce_out, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_lost_cnt", lost_cnt, 0);

        // release latency
        pll_lock = 1'b1;
        wait_release(n);
        chk("release_latency", n, REL);
        chk("release_ready", ready, 1);
        chk("release_ce", ce_out, 4'b1111);

        // glitch midway through STABLE
        do_reset();
        pll_lock = 1'b1;
        repeat (8) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        chk("glitch_rst_out", rst_out, 1);
        pll_lock = 1'b1;
        wait_release(n);
        chk("glitch_release_latency", n, REL);

        // divisor table, loaded outside RUN
        for (int r = 0; r < 3; r++) begin
            do_reset();
            load_div(vecs[r].div);
            pll_lock = 1'b1;
            wait_release(n);
            chk($sformatf("tbl%0d_release", r), n, REL);
            coinc = 0;
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("tbl%0d_ce_k%0d", r, k), ce_out, vecs[r].ce[k]);
                if (ce_out == 4'b1111) coinc++;
                tick();
            end
            if (r == 0) begin
                for (int k = 6; k < 60; k++) begin
                    for (int c = 0; c < 4; c++) exp_ce[c] = ((k % dmod[c]) == 0);
                    chk($sformatf("div_model_k%0d", k), ce_out, exp_ce);
                    if (ce_out == 4'b1111) coinc++;
                    tick();
                end
                chk("coincide_60", coinc, 2);
            end
        end

        // repeated loss in RUN
        do_reset();
        pll_lock = 1'b1;
        wait_release(n);
        chk("loss_pre_release", n, REL);
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick();
            pll_lock = 1'b0;
            wait_loss(n);
            chk($sformatf("loss%0d_latency_ok", i), (n >= 1 && n <= 3), 1);
            chk($sformatf("loss%0d_ce", i), ce_out, 0);
            chk($sformatf("loss%0d_ready", i), ready, 0);
            chk($sformatf("loss%0d_flag", i), lock_lost, 1);
            chk($sformatf("loss%0d_cnt", i), lost_cnt, exp_lost[i]);
            pll_lock = 1'b1;
            wait_release(n);
            chk($sformatf("loss%0d_rerelease", i), n, REL);
        end
        chk("loss_flag_sticky", lock_lost, 1);
        // loss coinciding with clear: loss wins
        pll_lock = 1'b0;
        tick();
        tick();
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        chk("coinc_rst_out", rst_out, 1);
        chk("coinc_flag", lock_lost, 1);
        chk("coinc_cnt", lost_cnt, 1);
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        chk("clear_flag", lock_lost, 0);
        chk("clear_cnt", lost_cnt, 0);

        // divisor change in RUN adopted at next period boundary
        do_reset();
        load_div({16'd1, 16'd1, 16'd1, 16'd4});
        pll_lock = 1'b1;
        wait_release(n);
        chk("chg_release", n, REL);
        chk("chg_ce0_k0", ce_out[0], 1);
        tick();
        chk("chg_ce0_k1", ce_out[0], 0);
        load_div({16'd1, 16'd1, 16'd1, 16'd2});
        for (int k = 2; k < 12; k++) begin
            chk($sformatf("chg_ce0_k%0d", k), ce_out[0], (k >= 4) && ((k % 2) == 0));
            tick();
        end

        // reset mid-RUN with lost_cnt=2
        do_reset();
        pll_lock = 1'b1;
        wait_release(n);
        for (int i = 0; i < 2; i++) begin
            pll_lock = 1'b0;
            wait_loss(n);
            pll_lock = 1'b1;
            wait_release(n);
        end
        load_div({16'd3, 16'd3, 16'd3, 16'd3});
        repeat (4) tick();
        chk("r6_pre_cnt", lost_cnt, 2);
        chk("r6_pre_ready", ready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r6_rst_out", rst_out, 1);
        chk("r6_ready", ready, 0);
        chk("r6_ce", ce_out, 0);
        chk("r6_lost_cnt", lost_cnt, 0);
        chk("r6_lock_lost", lock_lost, 0);
        wait_release(n);
        chk("r6_release", n, REL);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("r6_default_ce_k%0d", k), ce_out, 4'b1111);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
